// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the CPU read mux, with level/status and a threshold interrupt.
// Optional idle-timeout interrupt is compiled in with `define UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       thresh_we,
    input  logic [7:0] thresh_wdata,
    input  logic       clr_ovf,
    output logic [7:0] head_data,
    output logic [7:0] level,
    output logic [7:0] status,
    output logic       int_req
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [7:0]        DEPTH_BYTE = 8'(DEPTH);

    if ((DEPTH < 2) || (DEPTH > 128) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two in 2..128");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("uart_rx_fifo: TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr_reg, rptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic [7:0]       thresh_reg, thresh_next;
    logic             ovf_reg, ovf_next;
    logic             timeout_flag_reg, timeout_flag_next;
    logic             int_req_reg;
    logic             full, nonempty, push_ok, pop_ok;

    assign full     = (count_reg == FULL_COUNT);
    assign nonempty = (count_reg != '0);
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign pop_ok   = pop & nonempty;
    assign push_ok  = push & (~full | pop_ok);

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Overflow set beats a same-cycle clear.
    assign ovf_next = (push & ~push_ok) | (ovf_reg & ~clr_ovf);

    always_comb begin
        thresh_next = thresh_reg;
        if (thresh_we) begin
            if (thresh_wdata == 8'd0) begin
                thresh_next = 8'd1;
            end else if (thresh_wdata > DEPTH_BYTE) begin
                thresh_next = DEPTH_BYTE;
            end else begin
                thresh_next = thresh_wdata;
            end
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] idle_cnt_reg, idle_cnt_next;

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (push || pop || (count_next == '0)) begin
            idle_cnt_next = 16'd0;
        end else if (idle_cnt_reg != TIMEOUT_LIMIT) begin
            idle_cnt_next = idle_cnt_reg + 16'd1;
        end
    end

    assign timeout_flag_next = (idle_cnt_next == TIMEOUT_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt_reg <= 16'd0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`else
    assign timeout_flag_next = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_reg         <= '0;
            rptr_reg         <= '0;
            count_reg        <= '0;
            thresh_reg       <= 8'd1;
            ovf_reg          <= 1'b0;
            timeout_flag_reg <= 1'b0;
            int_req_reg      <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            count_reg        <= count_next;
            thresh_reg       <= thresh_next;
            ovf_reg          <= ovf_next;
            timeout_flag_reg <= timeout_flag_next;
            int_req_reg      <= (8'(count_next) >= thresh_next) | timeout_flag_next;
        end
    end

    assign head_data = nonempty ? mem[rptr_reg] : 8'h00;
    assign level     = 8'(count_reg);
    assign status    = {4'b0000, timeout_flag_reg, ovf_reg, full, nonempty};
    assign int_req   = int_req_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH 16, TIMEOUT_CYCLES 10); build with or without UART_RX_FIFO_TIMEOUT_EN.
module tb_uart_rx_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       pop = 1'b0;
    logic       thresh_we = 1'b0;
    logic [7:0] thresh_wdata = 8'h00;
    logic       clr_ovf = 1'b0;
    logic [7:0] head_data;
    logic [7:0] level;
    logic [7:0] status;
    logic       int_req;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_fifo #(
        .DEPTH          (16),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .thresh_we    (thresh_we),
        .thresh_wdata (thresh_wdata),
        .clr_ovf      (clr_ovf),
        .head_data    (head_data),
        .level        (level),
        .status       (status),
        .int_req      (int_req)
    );

    always #5 clock = ~clock;

    // One clock of stimulus; outputs are stable 1 time unit after the edge.
    task automatic drive(input logic p, input logic [7:0] d, input logic q,
                         input logic tw = 1'b0, input logic [7:0] td = 8'h00,
                         input logic co = 1'b0);
        push = p; push_data = d; pop = q;
        thresh_we = tw; thresh_wdata = td; clr_ovf = co;
        @(posedge clock);
        #1;
        push = 1'b0; pop = 1'b0; thresh_we = 1'b0; clr_ovf = 1'b0;
        $display("txn push=%0b data=%02h pop=%0b twe=%0b tdata=%0d clr=%0b -> level=%0d head=%02h status=%02h int=%0b",
                 p, d, q, tw, td, co, level, head_data, status, int_req);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (level !== 8'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
        vectors++;
        if (status !== 8'h00) begin miscompares++; $display("FAIL reset_status got %02h want 00", status); end
        vectors++;
        if (head_data !== 8'h00) begin miscompares++; $display("FAIL reset_head got %02h want 00", head_data); end
        vectors++;
        if (int_req !== 1'b0) begin miscompares++; $display("FAIL reset_int got %0b want 0", int_req); end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic;
        drive(1'b1, 8'hA5, 1'b0);
        vectors++;
        if (int_req !== 1'b1) begin miscompares++; $display("FAIL basic_int_first got %0b want 1", int_req); end
        drive(1'b1, 8'h3C, 1'b0);
        vectors++;
        if (level !== 8'd2) begin miscompares++; $display("FAIL basic_level got %0d want 2", level); end
        vectors++;
        if (head_data !== 8'hA5) begin miscompares++; $display("FAIL basic_head got %02h want a5", head_data); end
        vectors++;
        if (status !== 8'h01) begin miscompares++; $display("FAIL basic_status got %02h want 01", status); end
        drive(1'b0, 8'h00, 1'b1);
        vectors++;
        if (head_data !== 8'h3C) begin miscompares++; $display("FAIL basic_pop_head got %02h want 3c", head_data); end
        vectors++;
        if (level !== 8'd1) begin miscompares++; $display("FAIL basic_pop_level got %0d want 1", level); end
        drive(1'b0, 8'h00, 1'b1);
        vectors++;
        if (int_req !== 1'b0 || level !== 8'd0) begin
            miscompares++; $display("FAIL basic_drain got int=%0b level=%0d want int=0 level=0", int_req, level);
        end
    endtask

    task automatic test_threshold;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
        vectors++;
        if (int_req !== 1'b0) begin miscompares++; $display("FAIL thresh_zero_as_one got %0b want 0", int_req); end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b0);
            vectors++;
            if (int_req !== 1'b0) begin miscompares++; $display("FAIL thresh_below push%0d got %0b want 0", i, int_req); end
        end
        drive(1'b1, 8'h53, 1'b0);
        vectors++;
        if (int_req !== 1'b1 || level !== 8'd4) begin
            miscompares++; $display("FAIL thresh_reach got int=%0b level=%0d want int=1 level=4", int_req, level);
        end
        drive(1'b0, 8'h00, 1'b1);
        vectors++;
        if (int_req !== 1'b0) begin miscompares++; $display("FAIL thresh_pop got %0b want 0", int_req); end
        // Threshold write takes effect on its own edge against level 3.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd2);
        vectors++;
        if (int_req !== 1'b1) begin miscompares++; $display("FAIL thresh_write_now got %0b want 1", int_req); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
        end
        vectors++;
        if (level !== 8'd0 || int_req !== 1'b0) begin
            miscompares++; $display("FAIL thresh_drain got level=%0d int=%0b want 0 0", level, int_req);
        end
    endtask

    task automatic test_overflow;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd200);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            vectors++;
            if (level !== 8'(i + 1) || int_req !== (i == 15)) begin
                miscompares++;
                $display("FAIL ovf_fill%0d got level=%0d int=%0b want level=%0d int=%0b", i, level, int_req, i + 1, (i == 15));
            end
        end
        drive(1'b1, 8'h10, 1'b0);
        vectors++;
        if (level !== 8'd16) begin miscompares++; $display("FAIL ovf_level got %0d want 16", level); end
        vectors++;
        if (status !== 8'h07) begin miscompares++; $display("FAIL ovf_status got %02h want 07", status); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (head_data !== 8'(i)) begin miscompares++; $display("FAIL ovf_order%0d got %02h want %02h", i, head_data, 8'(i)); end
            drive(1'b0, 8'h00, 1'b1);
        end
        vectors++;
        if (status !== 8'h04) begin miscompares++; $display("FAIL ovf_sticky got %02h want 04", status); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        vectors++;
        if (status !== 8'h00) begin miscompares++; $display("FAIL ovf_clear got %02h want 00", status); end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd1);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b0);
        end
        drive(1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b1);
        vectors++;
        if (status !== 8'h07) begin miscompares++; $display("FAIL full_ovf_beats_clr got %02h want 07", status); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'hEE, 1'b1);
        vectors++;
        if (level !== 8'd16 || status !== 8'h03) begin
            miscompares++; $display("FAIL full_pushpop got level=%0d status=%02h want 16 03", level, status);
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp;
            exp = (i == 15) ? 8'hEE : 8'(8'h21 + i);
            vectors++;
            if (head_data !== exp) begin miscompares++; $display("FAIL full_order%0d got %02h want %02h", i, head_data, exp); end
            drive(1'b0, 8'h00, 1'b1);
        end
        drive(1'b1, 8'h11, 1'b1);
        vectors++;
        if (level !== 8'd1 || head_data !== 8'h11) begin
            miscompares++; $display("FAIL empty_pushpop got level=%0d head=%02h want 1 11", level, head_data);
        end
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        vectors++;
        if (level !== 8'd0 || status !== 8'h00) begin
            miscompares++; $display("FAIL empty_pop got level=%0d status=%02h want 0 00", level, status);
        end
    endtask

    task automatic test_timeout;
        logic       exp_flag;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd4);
        drive(1'b1, 8'h77, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 8'h00, 1'b0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
            exp_flag = (k >= 10);
`else
            exp_flag = 1'b0;
`endif
            vectors++;
            if (status[3] !== exp_flag || int_req !== exp_flag) begin
                miscompares++;
                $display("FAIL timeout_idle%0d got flag=%0b int=%0b want %0b %0b", k, status[3], int_req, exp_flag, exp_flag);
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        vectors++;
        if (status !== 8'h00 || int_req !== 1'b0) begin
            miscompares++; $display("FAIL timeout_pop got status=%02h int=%0b want 00 0", status, int_req);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd1);
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'(8'h80 + i), 1'b0);
            vectors++;
            if (head_data !== 8'(8'h80 + i) || level !== 8'd1) begin
                miscompares++;
                $display("FAIL wrap%0d got head=%02h level=%0d want %02h 1", i, head_data, level, 8'(8'h80 + i));
            end
            drive(1'b0, 8'h00, 1'b1);
            vectors++;
            if (level !== 8'd0) begin miscompares++; $display("FAIL wrap_pop%0d got level=%0d want 0", i, level); end
        end
    endtask

    task automatic test_reset_midburst;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (level !== 8'd0 || head_data !== 8'h00 || status !== 8'h00 || int_req !== 1'b0) begin
            miscompares++;
            $display("FAIL midburst_reset got level=%0d head=%02h status=%02h int=%0b want 0 00 00 0", level, head_data, status, int_req);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        drive(1'b1, 8'h5A, 1'b0);
        vectors++;
        if (int_req !== 1'b1 || head_data !== 8'h5A) begin
            miscompares++; $display("FAIL reset_thresh_restored got int=%0b head=%02h want 1 5a", int_req, head_data);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_threshold;
        test_overflow;
        test_back_to_back;
        test_timeout;
        test_wrap;
        test_reset_midburst;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
